// File: rtl/pieo_pre_enq_tracker_if.sv
// Enqueue handshake between the pre-enqueue tracker and the PIEO.
// master: drives enq_valid/enq_element, samples enq_ready; slave: reverse.
interface pieo_pre_enq_tracker_if #(
   parameter int EW = 4
);
   logic          enq_valid;
   logic          enq_ready;
   logic [EW-1:0] enq_element;

   modport master (
      output enq_valid,
      output enq_element,
      input  enq_ready
   );

   modport slave (
      input  enq_valid,
      input  enq_element,
      output enq_ready
   );
endinterface

// File: rtl/pieo_pre_enq_tracker.sv
// Enqueue-side flow tracker: keeps one element per backlogged queue in the PIEO.
// Ports: clk/rst, en_in, per-queue fifo/feedback/params, enq (handshake), status.
module pieo_pre_enq_tracker #(
   parameter int NUM_QUEUES = 3,
   parameter int ID_LOG     = $clog2(NUM_QUEUES),
   parameter int RANK_LOG   = 1,
   parameter int TIME_LOG   = 1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           en_in,
   input  logic [NUM_QUEUES-1:0]          fifo_tvalid,
   input  logic [NUM_QUEUES-1:0]          tb_fifo_eligible,
   input  logic [NUM_QUEUES-1:0]          post_deq_end,
   input  logic [NUM_QUEUES*RANK_LOG-1:0] fifo_rank,
   input  logic [NUM_QUEUES*TIME_LOG-1:0] fifo_hold_time,
   pieo_pre_enq_tracker_if.master         enq,
   output logic [NUM_QUEUES-1:0]          queue_scheduled,
   output logic [TIME_LOG-1:0]            now,
   output logic                           spurious_end
);

   localparam int EW = ID_LOG + RANK_LOG + TIME_LOG;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PENDING = 2'd1,
      SCHED   = 2'd2
   } qstate_t;

   qstate_t st_q [NUM_QUEUES];
   qstate_t st_d [NUM_QUEUES];

   logic                  valid_q;
   logic [EW-1:0]         elem_q;
   logic [ID_LOG-1:0]     slot_id_q;
   logic [ID_LOG-1:0]     rr_ptr_q;

   logic                  accept;
   logic                  slot_free;
   logic                  found;
   logic                  grant;
   logic [ID_LOG-1:0]     gnt_id;
   logic [ID_LOG-1:0]     rr_next;
   logic [ID_LOG:0]       idx;
   logic [TIME_LOG-1:0]   gnt_time;
   logic [NUM_QUEUES-1:0] cand;
   logic [NUM_QUEUES-1:0] spur_hit;
   logic [NUM_QUEUES-1:0] sched_d;
   logic [RANK_LOG-1:0]   rank_a [NUM_QUEUES];
   logic [TIME_LOG-1:0]   hold_a [NUM_QUEUES];

   assign accept    = valid_q & enq.enq_ready;
   assign slot_free = ~valid_q | enq.enq_ready;

   assign enq.enq_valid   = valid_q;
   assign enq.enq_element = elem_q;

   // Per-queue next state; the queue sitting in the slot stays PENDING
   // until the PIEO accepts it, so it is excluded from re-selection.
   always_comb begin
      cand     = '0;
      spur_hit = '0;
      sched_d  = '0;
      for (int q = 0; q < NUM_QUEUES; q++) begin
         rank_a[q] = fifo_rank[q*RANK_LOG +: RANK_LOG];
         hold_a[q] = fifo_hold_time[q*TIME_LOG +: TIME_LOG];
         st_d[q]   = st_q[q];
         cand[q]   = (st_q[q] == PENDING) &&
                     !(valid_q && slot_id_q == ID_LOG'(q));
         spur_hit[q] = post_deq_end[q] && (st_q[q] != SCHED);
         if (st_q[q] == SCHED && post_deq_end[q])
            st_d[q] = fifo_tvalid[q] ? PENDING : IDLE;
         else if (st_q[q] == PENDING && accept &&
                  slot_id_q == ID_LOG'(q))
            st_d[q] = SCHED;
         else if (st_q[q] == IDLE && fifo_tvalid[q])
            st_d[q] = PENDING;
         sched_d[q] = (st_d[q] != IDLE);
      end
   end

   // Round-robin: first candidate at or after rr_ptr, wrapping.
   always_comb begin
      found  = 1'b0;
      gnt_id = '0;
      idx    = '0;
      for (int i = 0; i < NUM_QUEUES; i++) begin
         idx = {1'b0, rr_ptr_q} + (ID_LOG+1)'(i);
         if (idx >= (ID_LOG+1)'(NUM_QUEUES))
            idx = idx - (ID_LOG+1)'(NUM_QUEUES);
         if (!found && cand[idx[ID_LOG-1:0]]) begin
            found  = 1'b1;
            gnt_id = idx[ID_LOG-1:0];
         end
      end
   end

   assign grant   = found & slot_free & en_in;
   assign rr_next = (gnt_id == ID_LOG'(NUM_QUEUES-1)) ?
                    '0 : gnt_id + 1'b1;
   // Carry out of the sum is dropped: the virtual clock wraps.
   assign gnt_time = tb_fifo_eligible[gnt_id] ?
                     now : now + hold_a[gnt_id];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int q = 0; q < NUM_QUEUES; q++)
            st_q[q] <= IDLE;
         valid_q         <= 1'b0;
         elem_q          <= '0;
         slot_id_q       <= '0;
         rr_ptr_q        <= '0;
         queue_scheduled <= '0;
         now             <= '0;
         spurious_end    <= 1'b0;
      end else begin
         for (int q = 0; q < NUM_QUEUES; q++)
            st_q[q] <= st_d[q];
         queue_scheduled <= sched_d;
         spurious_end    <= |spur_hit;
         if (en_in)
            now <= now + 1'b1;
         if (grant) begin
            valid_q   <= 1'b1;
            elem_q    <= {gnt_time, rank_a[gnt_id], gnt_id};
            slot_id_q <= gnt_id;
            rr_ptr_q  <= rr_next;
         end else if (accept) begin
            valid_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pieo_pre_enq_tracker.sv
// Bench for pieo_pre_enq_tracker: directed scenarios plus random traffic
// compared every cycle against a queue-level reference model.
module tb_pieo_pre_enq_tracker;

   localparam int NQ = 3;
   localparam int RL = 4;
   localparam int TL = 4;
   localparam int EW = 2 + RL + TL;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst, en_in, rdy;
   logic [NQ-1:0]  tv, elig, pde;
   logic [NQ*RL-1:0] rank_v;
   logic [NQ*TL-1:0] hold_v;
   logic [NQ-1:0]  qs;
   logic [TL-1:0]  now;
   logic           spur;

   pieo_pre_enq_tracker_if #(.EW(EW)) eif ();
   assign eif.enq_ready = rdy;

   pieo_pre_enq_tracker #(
      .NUM_QUEUES(NQ),
      .RANK_LOG(RL),
      .TIME_LOG(TL)
   ) dut (
      .clk(clk),
      .rst(rst),
      .en_in(en_in),
      .fifo_tvalid(tv),
      .tb_fifo_eligible(elig),
      .post_deq_end(pde),
      .fifo_rank(rank_v),
      .fifo_hold_time(hold_v),
      .enq(eif),
      .queue_scheduled(qs),
      .now(now),
      .spurious_end(spur)
   );

   // Reference model: 0 idle, 1 waiting for enqueue, 2 held by the PIEO.
   int            m_st [NQ];
   bit            m_valid;
   int            m_id, m_rr, m_now;
   logic [EW-1:0] m_elem;
   bit            m_spur;

   int checks = 0;
   int errors = 0;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic model_step();
      bit acc;
      bit sp;
      bit fnd;
      int g, q, t;
      int ns [NQ];
      if (rst) begin
         for (int i = 0; i < NQ; i++) m_st[i] = 0;
         m_valid = 0; m_id = 0; m_rr = 0; m_now = 0;
         m_elem = '0; m_spur = 0;
         return;
      end
      acc = m_valid && rdy;
      sp = 0; fnd = 0; g = 0;
      for (int i = 0; i < NQ; i++) begin
         ns[i] = m_st[i];
         if (pde[i] && m_st[i] == 2) ns[i] = tv[i] ? 1 : 0;
         else if (m_st[i] == 1 && acc && m_id == i) ns[i] = 2;
         else if (m_st[i] == 0 && tv[i]) ns[i] = 1;
         if (pde[i] && m_st[i] != 2) sp = 1;
      end
      if ((!m_valid || rdy) && en_in)
         for (int k = 0; k < NQ; k++) begin
            q = (m_rr + k) % NQ;
            if (!fnd && m_st[q] == 1 && !(m_valid && m_id == q)) begin
               fnd = 1; g = q;
            end
         end
      if (fnd) begin
         t = elig[g] ? m_now : (m_now + int'(hold_v[g*TL +: TL])) % 16;
         m_elem  = {4'(t), rank_v[g*RL +: RL], 2'(g)};
         m_valid = 1;
         m_id    = g;
         m_rr    = (g + 1) % NQ;
      end else if (acc) begin
         m_valid = 0;
      end
      if (en_in) m_now = (m_now + 1) % 16;
      m_spur = sp;
      for (int i = 0; i < NQ; i++) m_st[i] = ns[i];
   endtask

   task automatic compare();
      logic [NQ-1:0] eq;
      for (int i = 0; i < NQ; i++) eq[i] = (m_st[i] != 0);
      chk("enq_valid", 32'(eif.enq_valid), 32'(m_valid));
      chk("enq_element", 32'(eif.enq_element), 32'(m_elem));
      chk("queue_scheduled", 32'(qs), 32'(eq));
      chk("now", 32'(now), 32'(m_now));
      chk("spurious_end", 32'(spur), 32'(m_spur));
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare();
   endtask

   task automatic do_reset();
      tv = '0; pde = '0;
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; en_in = 1'b1; rdy = 1'b1;
      tv = '0; elig = '1; pde = '0;
      rank_v = '0; hold_v = '0;
      step(); step();
      chk("rst_valid", 32'(eif.enq_valid), 32'd0);
      chk("rst_element", 32'(eif.enq_element), 32'd0);
      chk("rst_qs", 32'(qs), 32'd0);
      chk("rst_now", 32'(now), 32'd0);
      rst = 1'b0;

      // Single queue.
      repeat (9) step();
      tv = 3'b010; rank_v[7:4] = 4'd5;
      step();
      chk("single_qs", 32'(qs), 32'b010);
      chk("single_pend_valid", 32'(eif.enq_valid), 32'd0);
      step();
      chk("single_valid", 32'(eif.enq_valid), 32'd1);
      chk("single_elem", 32'(eif.enq_element), 32'({4'd10, 4'd5, 2'd1}));
      step();
      chk("single_acc_valid", 32'(eif.enq_valid), 32'd0);

      // Round robin with backpressure.
      do_reset();
      rdy = 1'b0; tv = 3'b111;
      step();
      chk("rr_qs", 32'(qs), 32'b111);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("rr_hold_valid", 32'(eif.enq_valid), 32'd1);
         chk("rr_hold_id", 32'(eif.enq_element[1:0]), 32'd0);
      end
      rdy = 1'b1;
      step();
      chk("rr_id1", 32'(eif.enq_element[1:0]), 32'd1);
      step();
      chk("rr_id2", 32'(eif.enq_element[1:0]), 32'd2);
      chk("rr_id2_valid", 32'(eif.enq_valid), 32'd1);
      step();
      chk("rr_drain", 32'(eif.enq_valid), 32'd0);

      // Time wrap.
      do_reset();
      repeat (13) step();
      chk("wrap_now", 32'(now), 32'd13);
      tv = 3'b100; elig = 3'b011;
      hold_v[11:8] = 4'd5; rank_v[11:8] = 4'd7;
      step(); step();
      chk("wrap_elem", 32'(eif.enq_element), 32'({4'd3, 4'd7, 2'd2}));
      elig = '1;

      // Re-arm and go idle.
      do_reset();
      tv = 3'b001;
      step(); step();
      chk("rearm_first", 32'(eif.enq_valid), 32'd1);
      step();
      chk("rearm_sched", 32'(qs), 32'b001);
      pde = 3'b001;
      step();
      pde = '0;
      chk("rearm_gap", 32'(eif.enq_valid), 32'd0);
      step();
      chk("rearm_again", 32'(eif.enq_valid), 32'd1);
      chk("rearm_id", 32'(eif.enq_element[1:0]), 32'd0);
      step();
      tv = '0; pde = 3'b001;
      step();
      pde = '0;
      chk("idle_qs", 32'(qs), 32'b000);
      step();
      chk("idle_valid", 32'(eif.enq_valid), 32'd0);

      // Spurious end on an idle queue.
      pde = 3'b100;
      step();
      pde = '0;
      chk("spur_hi", 32'(spur), 32'd1);
      chk("spur_qs", 32'(qs), 32'd0);
      step();
      chk("spur_lo", 32'(spur), 32'd0);

      // Enable gating, then reset with a valid element.
      en_in = 1'b0;
      do_reset();
      tv = 3'b011;
      repeat (3) step();
      chk("en_valid", 32'(eif.enq_valid), 32'd0);
      chk("en_now", 32'(now), 32'd0);
      chk("en_qs", 32'(qs), 32'b011);
      en_in = 1'b1; rdy = 1'b0;
      step();
      chk("en_grant", 32'(eif.enq_valid), 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mrst_valid", 32'(eif.enq_valid), 32'd0);
      chk("mrst_elem", 32'(eif.enq_element), 32'd0);
      chk("mrst_qs", 32'(qs), 32'd0);
      chk("mrst_now", 32'(now), 32'd0);

      // Random traffic.
      for (int n = 0; n < 3000; n++) begin
         rst    = ($urandom % 150) == 0;
         en_in  = ($urandom % 8) != 0;
         rdy    = ($urandom % 3) != 0;
         tv     = 3'($urandom);
         elig   = 3'($urandom);
         rank_v = 12'($urandom);
         hold_v = 12'($urandom);
         for (int i = 0; i < NQ; i++)
            pde[i] = (m_st[i] == 2 && ($urandom % 4) == 0) ||
                     (($urandom % 40) == 0);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
